// File: rtl/sysid_verifier_pkg.sv
// Shared types and constants for the boot-time system-ID verifier.
// Contents: FSM state enum, slave word offsets, default expected values,
//           and small state-classification helpers used by the top FSM.
package sysid_verifier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ID_REQ  = 3'd1,
        ST_ID_WAIT = 3'd2,
        ST_TS_REQ  = 3'd3,
        ST_TS_WAIT = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Word offsets inside the two-word system-ID slave.
    localparam logic SYSID_ID_OFFSET = 1'b0;
    localparam logic SYSID_TS_OFFSET = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1490658802;
    localparam int          DEFAULT_TIMEOUT_CYCLES     = 255;

    // Request phase: read strobe is on the bus.
    function automatic logic is_req(input state_t s);
        return (s == ST_ID_REQ) || (s == ST_TS_REQ);
    endfunction

    // Response phase: read accepted, waiting for readdatavalid.
    function automatic logic is_wait(input state_t s);
        return (s == ST_ID_WAIT) || (s == ST_TS_WAIT);
    endfunction

    // Timestamp phase selects the second slave word.
    function automatic logic is_ts_phase(input state_t s);
        return (s == ST_TS_REQ) || (s == ST_TS_WAIT);
    endfunction

endpackage

// File: rtl/sysid_verifier_if.sv
// Avalon-MM read-only bus between the verifier (master) and the system-ID slave.
// Signals: word address, read strobe, waitrequest stall, 32-bit read data and
//          its readdatavalid strobe. No write path: the slave is read-only.
interface sysid_verifier_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );

endinterface

// File: rtl/sysid_verifier_avm_single_read.sv
// Single Avalon-MM read engine with waitrequest hold and per-read timeout counter.
// Ports: clock/reset; clear_i/req_i/wait_i/address_i phase controls from the owning FSM;
//        avm master bus; accepted_o/ok_o/timed_out_o status strobes and data_o read data.
module avm_single_read #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             req_i,
    input  logic             wait_i,
    input  logic             address_i,
    sysid_verifier_if.master avm,
    output logic             accepted_o,
    output logic             ok_o,
    output logic             timed_out_o,
    output logic [31:0]      data_o
);

    localparam int             CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          limit_hit;

    assign limit_hit = (cnt_q == CNT_LIMIT);

    // Counter restarts at each new request and holds at the limit so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if ((req_i || wait_i) && !limit_hit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Strobe and address come straight from the registered FSM phase, so they
    // stay stable for as long as the slave holds waitrequest.
    assign avm.avm_read    = req_i;
    assign avm.avm_address = address_i;

    // A response landing in the very cycle the limit is reached still counts.
    assign ok_o        = wait_i && avm.avm_readdatavalid;
    assign accepted_o  = req_i && !avm.avm_waitrequest && !limit_hit;
    assign timed_out_o = (req_i || wait_i) && limit_hit && !ok_o;
    assign data_o      = avm.avm_readdata;

endmodule

// File: rtl/sysid_verifier.sv
// Boot-time sequencer: reads system ID and build timestamp, compares with expected values.
// Ports: clock/reset/start control; avm master bus to the system-ID slave;
//        busy/done status, pass verdict, sticky mismatch/timeout flags and captured words.
module sysid_verifier
    import sysid_verifier_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int          TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES  // must be >= 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    sysid_verifier_if.master avm,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             id_mismatch,
    output logic             ts_mismatch,
    output logic             timeout,
    output logic [31:0]      captured_id,
    output logic [31:0]      captured_ts
);

    state_t      state_q;
    state_t      state_d;

    logic        pass_q;
    logic        id_mm_q;
    logic        ts_mm_q;
    logic        timeout_q;
    logic [31:0] cap_id_q;
    logic [31:0] cap_ts_q;

    logic        rd_clear;
    logic        rd_req;
    logic        rd_wait;
    logic        rd_addr;
    logic        rd_accepted;
    logic        rd_ok;
    logic        rd_timed_out;
    logic [31:0] rd_data;

    assign rd_req  = is_req(state_q);
    assign rd_wait = is_wait(state_q);
    assign rd_addr = is_ts_phase(state_q) ? SYSID_TS_OFFSET : SYSID_ID_OFFSET;

    // Fresh timeout budget whenever a request phase is entered.
    assign rd_clear = ((state_d == ST_ID_REQ) && (state_q != ST_ID_REQ)) ||
                      ((state_d == ST_TS_REQ) && (state_q != ST_TS_REQ));

    avm_single_read #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_read (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (rd_clear),
        .req_i       (rd_req),
        .wait_i      (rd_wait),
        .address_i   (rd_addr),
        .avm         (avm),
        .accepted_o  (rd_accepted),
        .ok_o        (rd_ok),
        .timed_out_o (rd_timed_out),
        .data_o      (rd_data)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_ID_REQ;
            ST_ID_REQ: begin
                if (rd_timed_out)     state_d = ST_DONE;
                else if (rd_accepted) state_d = ST_ID_WAIT;
            end
            ST_ID_WAIT: begin
                if (rd_ok)             state_d = ST_TS_REQ;
                else if (rd_timed_out) state_d = ST_DONE;
            end
            ST_TS_REQ: begin
                if (rd_timed_out)     state_d = ST_DONE;
                else if (rd_accepted) state_d = ST_TS_WAIT;
            end
            ST_TS_WAIT: begin
                if (rd_ok)             state_d = ST_CHECK;
                else if (rd_timed_out) state_d = ST_DONE;
            end
            ST_CHECK:   state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pass_q    <= 1'b0;
            id_mm_q   <= 1'b0;
            ts_mm_q   <= 1'b0;
            timeout_q <= 1'b0;
            cap_id_q  <= '0;
            cap_ts_q  <= '0;
        end else begin
            state_q <= state_d;

            if ((state_q == ST_IDLE) && start) begin
                pass_q    <= 1'b0;
                id_mm_q   <= 1'b0;
                ts_mm_q   <= 1'b0;
                timeout_q <= 1'b0;
            end

            // Only responses inside the matching wait phase are captured;
            // late or spurious readdatavalid pulses fall through untouched.
            if ((state_q == ST_ID_WAIT) && rd_ok) cap_id_q <= rd_data;
            if ((state_q == ST_TS_WAIT) && rd_ok) cap_ts_q <= rd_data;

            if (rd_timed_out) timeout_q <= 1'b1;

            // Verdict is registered here so it is already valid in the DONE cycle.
            // A timeout bypasses this state, leaving both mismatch flags and pass at 0.
            if (state_q == ST_CHECK) begin
                id_mm_q <= (cap_id_q != EXPECTED_ID);
                ts_mm_q <= (cap_ts_q != EXPECTED_TIMESTAMP);
                pass_q  <= (cap_id_q == EXPECTED_ID) &&
                           (cap_ts_q == EXPECTED_TIMESTAMP) && !timeout_q;
            end
        end
    end

    // All outputs decode registered state only.
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign pass        = pass_q;
    assign id_mismatch = id_mm_q;
    assign ts_mismatch = ts_mm_q;
    assign timeout     = timeout_q;
    assign captured_id = cap_id_q;
    assign captured_ts = cap_ts_q;

endmodule

// File: tb/tb_sysid_verifier.sv
// Self-checking bench for sysid_verifier: directed table, reset/restart sequences, random runs.
// Ports: none; drives clock/reset/start and a configurable Avalon slave through the bus interface.
module tb_sysid_verifier;

    localparam int          T      = 8;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1490658802;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] captured_id, captured_ts;

    sysid_verifier_if vif();

    sysid_verifier #(.TIMEOUT_CYCLES(T)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .avm         (vif),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .id_mismatch (id_mismatch),
        .ts_mismatch (ts_mismatch),
        .timeout     (timeout),
        .captured_id (captured_id),
        .captured_ts (captured_ts)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave behaviour per offset: stall cycles, response latency, data.
    int          cfg_s [2];
    int          cfg_l [2];
    logic [31:0] cfg_d [2];
    int          pend = 0;
    int          wcnt = 0;
    logic [31:0] pdat = '0;

    initial begin
        vif.avm_waitrequest   = 1'b0;
        vif.avm_readdatavalid = 1'b0;
        vif.avm_readdata      = '0;
        forever begin
            @(negedge clock);
            vif.avm_readdatavalid = 1'b0;
            vif.avm_waitrequest   = 1'b0;
            vif.avm_readdata      = $urandom;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    vif.avm_readdatavalid = 1'b1;
                    vif.avm_readdata      = pdat;
                end
            end
            if (vif.avm_read === 1'b1) begin
                if (wcnt < cfg_s[vif.avm_address]) begin
                    vif.avm_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    wcnt = 0;
                    pend = cfg_l[vif.avm_address];
                    pdat = cfg_d[vif.avm_address];
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    int          obs_done;
    logic        obs_pass, obs_idmm, obs_tsmm, obs_to, obs_hold, obs_idle;
    logic [31:0] obs_capid, obs_capts;

    // One complete check; start is also pulsed at every cycle c whose mask bit is set.
    task automatic run_check(input int s1, input int l1, input logic [31:0] d1,
                             input int s2, input int l2, input logic [31:0] d2,
                             input logic [31:0] mask);
        logic pr, pw, pa;
        cfg_s[0] = s1; cfg_l[0] = l1; cfg_d[0] = d1;
        cfg_s[1] = s2; cfg_l[1] = l2; cfg_d[1] = d2;
        for (int i = 0; i < 40 && (pend != 0 || vif.avm_readdatavalid); i++) tick();
        tick();
        start = 1'b1;
        obs_done = -1; obs_hold = 1'b1; obs_idle = 1'b1;
        obs_pass = 1'bx; obs_idmm = 1'bx; obs_tsmm = 1'bx; obs_to = 1'bx;
        pr = 1'b0; pw = 1'b0; pa = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            start = (c < 32) ? mask[c] : 1'b0;
            if (pr && pw && (vif.avm_read !== 1'b1 || vif.avm_address !== pa)) obs_hold = 1'b0;
            pr = vif.avm_read; pw = vif.avm_waitrequest; pa = vif.avm_address;
            if (obs_done < 0 && done === 1'b1) begin
                obs_done = c;
                obs_pass = pass; obs_idmm = id_mismatch;
                obs_tsmm = ts_mismatch; obs_to = timeout;
            end else if (obs_done > 0) begin
                if (busy !== 1'b0 || vif.avm_read !== 1'b0 || done !== 1'b0) obs_idle = 1'b0;
                if (c >= obs_done + 2 && pend == 0 && !vif.avm_readdatavalid) break;
            end
        end
        start = 1'b0;
        obs_capid = captured_id;
        obs_capts = captured_ts;
    endtask

    task automatic compare_obs(input string p, input int e_done, input logic e_pass,
                               input logic e_idmm, input logic e_tsmm, input logic e_to,
                               input logic [31:0] e_capid, input logic [31:0] e_capts);
        chk({p, "_done_cycle"}, 32'(obs_done), 32'(e_done));
        chk({p, "_pass"},       32'(obs_pass), 32'(e_pass));
        chk({p, "_id_mm"},      32'(obs_idmm), 32'(e_idmm));
        chk({p, "_ts_mm"},      32'(obs_tsmm), 32'(e_tsmm));
        chk({p, "_timeout"},    32'(obs_to),   32'(e_to));
        chk({p, "_cap_id"},     obs_capid,     e_capid);
        chk({p, "_cap_ts"},     obs_capts,     e_capts);
        chk({p, "_hold"},       32'(obs_hold), 32'd1);
        chk({p, "_idle_after"}, 32'(obs_idle), 32'd1);
    endtask

    typedef struct {
        int          s1, l1; logic [31:0] d1;
        int          s2, l2; logic [31:0] d2;
        logic [31:0] mask;
        int          e_done;
        logic        e_pass, e_idmm, e_tsmm, e_to;
        logic [31:0] e_capid, e_capts;
    } vec_t;

    vec_t tab [8];

    task automatic check_reset_outputs(input string p);
        chk({p, "_busy"},   32'(busy),            32'd0);
        chk({p, "_done"},   32'(done),            32'd0);
        chk({p, "_flags"},  32'({pass, id_mismatch, ts_mismatch, timeout}), 32'd0);
        chk({p, "_read"},   32'(vif.avm_read),    32'd0);
        chk({p, "_addr"},   32'(vif.avm_address), 32'd0);
        chk({p, "_cap_id"}, captured_id,          32'd0);
        chk({p, "_cap_ts"}, captured_ts,          32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s1, l1, s2, l2, e_done;
        logic [31:0] d1, d2, mask, m_capid, m_capts;
        logic        ok1, ok2, e_idmm, e_tsmm;

        // Directed vectors; captures carry over from one row to the next.
        tab[0] = '{0, 1, 32'd0,         0, 1,  EXP_TS,          32'h0,  6, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, EXP_TS};
        tab[1] = '{0, 1, 32'd5,         0, 1,  EXP_TS,          32'h0,  6, 1'b0, 1'b1, 1'b0, 1'b0, 32'd5, EXP_TS};
        tab[2] = '{3, 1, 32'd0,         3, 1,  EXP_TS,          32'h0, 12, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, EXP_TS};
        tab[3] = '{0, 1, 32'd0,         0, 10, 32'hDEADBEEF,    32'h0, 12, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, EXP_TS};
        tab[4] = '{0, 8, 32'd0,         0, 1,  EXP_TS,          32'h0, 13, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, EXP_TS};
        tab[5] = '{2, 7, 32'hDEADBEEF,  0, 1,  EXP_TS,          32'h0, 10, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, EXP_TS};
        tab[6] = '{0, 1, 32'd0,         1, 7,  EXP_TS + 32'd1,  32'h0, 13, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, EXP_TS + 32'd1};
        tab[7] = '{0, 1, 32'd1,         0, 1,  EXP_TS,          32'h44, 6, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, EXP_TS};

        cfg_s[0] = 0; cfg_l[0] = 1; cfg_d[0] = '0;
        cfg_s[1] = 0; cfg_l[1] = 1; cfg_d[1] = '0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        check_reset_outputs("por");
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_check(tab[i].s1, tab[i].l1, tab[i].d1, tab[i].s2, tab[i].l2, tab[i].d2, tab[i].mask);
            compare_obs($sformatf("vec%0d", i), tab[i].e_done, tab[i].e_pass, tab[i].e_idmm,
                        tab[i].e_tsmm, tab[i].e_to, tab[i].e_capid, tab[i].e_capts);
        end

        // Restart mid-read, then reset while the timestamp response is outstanding.
        cfg_s[0] = 0; cfg_l[0] = 1; cfg_d[0] = 32'd0;
        cfg_s[1] = 0; cfg_l[1] = 5; cfg_d[1] = EXP_TS;
        for (int i = 0; i < 40 && pend != 0; i++) tick();
        tick();
        start = 1'b1;
        tick();            // cycle 1: ID_REQ
        start = 1'b0;
        tick();            // cycle 2: ID_WAIT
        start = 1'b1;
        tick();            // cycle 3: TS_REQ
        start = 1'b0;
        chk("mid_addr_ts", 32'({vif.avm_read, vif.avm_address}), 32'd3);
        tick();            // cycle 4: TS_WAIT
        chk("mid_busy", 32'(busy), 32'd1);
        tick();            // cycle 5: TS_WAIT, reset sampled at the next edge
        reset = 1'b1;
        tick();            // cycle 6
        check_reset_outputs("mid_rst");
        reset = 1'b0;
        repeat (3) tick(); // abandoned response lands while idle
        chk("post_rst_cap_ts", captured_ts, 32'd0);
        chk("post_rst_busy",   32'(busy),   32'd0);
        run_check(0, 1, 32'd0, 0, 1, EXP_TS, 32'h0);
        compare_obs("after_rst", 6, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, EXP_TS);

        // Random runs checked against an outcome model built from phase lengths.
        m_capid = 32'd0;
        m_capts = EXP_TS;
        for (int r = 0; r < 40; r++) begin
            s1 = $urandom_range(0, 3); l1 = $urandom_range(1, T + 3 - s1);
            s2 = $urandom_range(0, 3); l2 = $urandom_range(1, T + 3 - s2);
            d1 = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
            d2 = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
            ok1 = (s1 + l1 <= T);
            ok2 = (s2 + l2 <= T);
            e_idmm = 1'b0;
            e_tsmm = 1'b0;
            if (!ok1) begin
                e_done = T + 2;
            end else begin
                m_capid = d1;
                if (!ok2) begin
                    e_done = (s1 + l1 + 1) + T + 2;
                end else begin
                    m_capts = d2;
                    e_idmm  = (d1 != EXP_ID);
                    e_tsmm  = (d2 != EXP_TS);
                    e_done  = (s1 + l1 + 1) + (s2 + l2 + 1) + 2;
                end
            end
            mask = $urandom & ((32'd1 << (e_done + 1)) - 32'd1);
            run_check(s1, l1, d1, s2, l2, d2, mask);
            compare_obs($sformatf("rnd%0d", r), e_done,
                        ok1 && ok2 && !e_idmm && !e_tsmm, e_idmm, e_tsmm,
                        !(ok1 && ok2), m_capid, m_capts);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sysid_verifier.md
# sysid_verifier

Boot-time sequencer that reads the two-word system-ID slave (offset 0 = system ID, offset 1 = build timestamp) over an Avalon-MM read master and compares both words against build-time expected values. It sits between the reset/boot controller and the system-ID slave's control port. It gives the boot path a single pass/fail verdict, with per-field mismatch and bus-timeout flags, before the processor is released.

## Interface
- EXPECTED_ID, default 32'd0, system ID the hardware must report
- EXPECTED_TIMESTAMP, default 32'd1490658802, build timestamp the hardware must report
- TIMEOUT_CYCLES, default 255, maximum cycles per read from request to readdatavalid; must be ≥ 2

- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to run a check; ignored while busy
- avm_address  out  1  word offset: 0 = ID, 1 = timestamp
- avm_read  out  1  Avalon read strobe
- avm_waitrequest  in  1  slave stall; hold address/read while high
- avm_readdata  in  32  read data, valid when avm_readdatavalid = 1
- avm_readdatavalid  in  1  read response strobe
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse when the verdict is final
- pass  out  1  both words matched and no timeout; sticky until next start
- id_mismatch  out  1  sticky
- ts_mismatch  out  1  sticky
- timeout  out  1  sticky
- captured_id  out  32  last ID word read
- captured_ts  out  32  last timestamp word read

## Operation
- States: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, CHECK, DONE.
- IDLE: start=1 → ID_REQ. Clear pass and all flags on that edge.
- ID_REQ:
  - avm_read=1, avm_address=0.
  - waitrequest=0 at the edge → ID_WAIT; otherwise stay, with address and read held stable.
- ID_WAIT: avm_read=0. readdatavalid=1 → latch captured_id, go to TS_REQ.
- TS_REQ / TS_WAIT: same as the ID states, using avm_address=1 and latching into captured_ts; exit to CHECK.
- CHECK: register id_mismatch = (captured_id ≠ EXPECTED_ID) and ts_mismatch = (captured_ts ≠ EXPECTED_TIMESTAMP) → DONE.
- DONE:
  - done=1 for this cycle only.
  - pass = !(id_mismatch | ts_mismatch | timeout).
  - Next state is IDLE.
- Timeout:
  - Per-read counter of width $clog2(TIMEOUT_CYCLES+1), cleared on entry to ID_REQ and TS_REQ, incremented each cycle in REQ/WAIT.
  - Counter reaching TIMEOUT_CYCLES without readdatavalid → timeout=1, drop avm_read immediately, go to DONE (CHECK is skipped), pass=0.
  - The mismatch flag of an unread field stays 0.
- readdatavalid outside ID_WAIT/TS_WAIT (late response after a timeout, or spurious) is ignored; captures are not updated.
- start while busy is ignored; start in the DONE cycle is ignored.
- reset at any cycle:
  - Returns to IDLE next edge; the read is abandoned.
  - All outputs go to their reset values: avm_read=0, avm_address=0, busy=0, done=0, pass=0, all flags 0, captures 0.

## Timing
- With waitrequest=0 and 1-cycle read latency, start is sampled at edge 0:
  - avm_read address 0 in cycle 1
  - readdatavalid in cycle 2
  - avm_read address 1 in cycle 3
  - readdatavalid in cycle 4
  - CHECK in cycle 5
  - done in cycle 6
- Each waitrequest cycle or extra latency cycle adds 1.
- Timeout verdict: done asserts exactly one cycle after the counter reaches TIMEOUT_CYCLES.
- Flags and captures update no later than the done cycle and are stable while done=1.
- No combinational path from any input to any output.

## Structure
- Package sysid_verifier_pkg:
  - state enum
  - SYSID_ID_OFFSET=1'b0, SYSID_TS_OFFSET=1'b1
  - default expected-value constants
- Sub-module avm_single_read:
  - Issues one Avalon read with waitrequest hold and a timeout counter.
  - Returns data/ok/timed_out.
  - Instantiated once and reused for both words by the top FSM.

## Test plan
- Slave returns 0 / 1490658802, no stalls, 1-cycle latency; start pulse → done in cycle 6, pass=1, both mismatch flags 0, captured_ts=1490658802.
- Slave returns 0x00000005 at offset 0 → done, pass=0, id_mismatch=1, ts_mismatch=0, captured_id=5.
- waitrequest high 3 cycles on each read → avm_address/avm_read held stable throughout; done in cycle 12; pass=1.
- TIMEOUT_CYCLES=8, slave never asserts readdatavalid on offset 1 → timeout=1, pass=0, ts_mismatch=0, avm_read low; a late readdatavalid with 0xDEADBEEF leaves captured_ts unchanged.
- start re-pulsed mid-check, then reset in TS_WAIT → second start ignored; after reset all outputs 0 and state IDLE; a new start runs a full check to pass=1.
